// File: rtl/axis_uart_tx_if.sv
// AXI-Stream word channel that feeds the UART transmitter.
interface axis_uart_tx_if #(
  parameter int Word_len = 8
);
  logic [Word_len-1:0] tx_data;
  logic                tx_data_valid;
  logic                tx_data_last;
  logic                tx_data_ready;

  modport master (output tx_data, output tx_data_valid, output tx_data_last, input tx_data_ready);
  modport slave  (input tx_data, input tx_data_valid, input tx_data_last, output tx_data_ready);
endinterface

// File: rtl/axis_uart_tx.sv
// AXI-Stream to UART serializer: start, LSB-first data, optional parity, stop bits,
// and an optional idle gap after the last word of a packet.
module axis_uart_tx #(
  parameter int clk_rate  = 100000000,
  parameter int Baud      = 115200,
  parameter int Word_len  = 8,
  parameter int Parity    = 0,
  parameter int Stop_bits = 1,
  parameter int Gap_bits  = 2
) (
  input  logic         clk,
  input  logic         rst,
  axis_uart_tx_if.slave s_axis,
  output logic         Uart_tx,
  output logic         tx_busy
);

  localparam int BAUD_DIV = clk_rate / Baud;
  localparam int CNT_W    = $clog2((BAUD_DIV < 2) ? 2 : BAUD_DIV);
  localparam int BIT_MAX  = (Word_len > Gap_bits) ? Word_len : Gap_bits;
  localparam int BIT_W    = $clog2(BIT_MAX);

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(Word_len - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(Stop_bits - 1);
  localparam logic [BIT_W-1:0] GAP_LAST  = BIT_W'((Gap_bits > 0) ? Gap_bits - 1 : 0);
  localparam bit               HAS_PAR   = (Parity != 0);
  localparam bit               HAS_GAP   = (Gap_bits > 0);

  if (BAUD_DIV < 2) begin : g_chk_div
    $error("axis_uart_tx: clk_rate/Baud must be at least 2");
  end
  if (Word_len < 5 || Word_len > 9) begin : g_chk_len
    $error("axis_uart_tx: Word_len must be 5..9");
  end
  if (Parity < 0 || Parity > 2) begin : g_chk_par
    $error("axis_uart_tx: Parity must be 0, 1 or 2");
  end
  if (Stop_bits < 1 || Stop_bits > 2) begin : g_chk_stop
    $error("axis_uart_tx: Stop_bits must be 1 or 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_GAP    = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [Word_len-1:0] shift_q, shift_d;
  logic                last_q, last_d;
  logic                par_q, par_d;
  logic                tx_q, tx_d;
  logic                bit_end;
  logic                par_calc;

  assign s_axis.tx_data_ready = (state_q == ST_IDLE);
  assign tx_busy              = (state_q != ST_IDLE);
  assign Uart_tx              = tx_q;
  assign par_calc = (Parity == 1) ? ~^s_axis.tx_data : ^s_axis.tx_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      last_q  <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      last_q  <= last_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    last_d  = last_q;
    par_d   = par_q;
    bit_end = (baud_q == DIV_LAST);

    if (state_q != ST_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (s_axis.tx_data_valid) begin
          state_d = ST_START;
          shift_d = s_axis.tx_data;
          last_d  = s_axis.tx_data_last;
          par_d   = par_calc;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      ST_START: begin
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = HAS_PAR ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = (last_q && HAS_GAP) ? ST_GAP : ST_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (bit_end) begin
          if (bit_q == GAP_LAST) begin
            bit_d   = '0;
            state_d = ST_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase

    // Line level is decoded from the next state so the flop output changes on the entering edge.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_axis_uart_tx.sv
// Bench for axis_uart_tx: four instances (8N1+gap, 8E1, 8O1, 7N2) at Baud_div = 10.
module tb_axis_uart_tx;

  localparam int DIV   = 10;
  localparam int DEPTH = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  logic [8:0] dat [4];
  logic       vld [4];
  logic       lst [4];
  logic [3:0] rdy, line, busy;
  logic       line_a, line_b, line_c, line_d;
  logic       busy_a, busy_b, busy_c, busy_d;

  logic ln [4][DEPTH];
  logic rd [4][DEPTH];

  typedef struct {
    int          id;
    int          acc;
    logic [15:0] bits;
    int          nb;
  } exp_t;
  exp_t exp_q[$];

  axis_uart_tx_if #(.Word_len(8)) if_a ();
  axis_uart_tx_if #(.Word_len(8)) if_b ();
  axis_uart_tx_if #(.Word_len(8)) if_c ();
  axis_uart_tx_if #(.Word_len(7)) if_d ();

  assign if_a.tx_data = dat[0][7:0];
  assign if_a.tx_data_valid = vld[0];
  assign if_a.tx_data_last = lst[0];
  assign if_b.tx_data = dat[1][7:0];
  assign if_b.tx_data_valid = vld[1];
  assign if_b.tx_data_last = lst[1];
  assign if_c.tx_data = dat[2][7:0];
  assign if_c.tx_data_valid = vld[2];
  assign if_c.tx_data_last = lst[2];
  assign if_d.tx_data = dat[3][6:0];
  assign if_d.tx_data_valid = vld[3];
  assign if_d.tx_data_last = lst[3];

  assign rdy  = {if_d.tx_data_ready, if_c.tx_data_ready, if_b.tx_data_ready, if_a.tx_data_ready};
  assign line = {line_d, line_c, line_b, line_a};
  assign busy = {busy_d, busy_c, busy_b, busy_a};

  axis_uart_tx #(.clk_rate(1000000), .Baud(100000), .Word_len(8), .Parity(0), .Stop_bits(1), .Gap_bits(2))
    dut_a (.clk(clk), .rst(rst), .s_axis(if_a.slave), .Uart_tx(line_a), .tx_busy(busy_a));
  axis_uart_tx #(.clk_rate(1000000), .Baud(100000), .Word_len(8), .Parity(2), .Stop_bits(1), .Gap_bits(2))
    dut_b (.clk(clk), .rst(rst), .s_axis(if_b.slave), .Uart_tx(line_b), .tx_busy(busy_b));
  axis_uart_tx #(.clk_rate(1000000), .Baud(100000), .Word_len(8), .Parity(1), .Stop_bits(1), .Gap_bits(2))
    dut_c (.clk(clk), .rst(rst), .s_axis(if_c.slave), .Uart_tx(line_c), .tx_busy(busy_c));
  axis_uart_tx #(.clk_rate(1000000), .Baud(100000), .Word_len(7), .Parity(0), .Stop_bits(2), .Gap_bits(2))
    dut_d (.clk(clk), .rst(rst), .s_axis(if_d.slave), .Uart_tx(line_d), .tx_busy(busy_d));

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < DEPTH) begin
      for (int k = 0; k < 4; k++) begin
        ln[k][cyc] <= line[k];
        rd[k][cyc] <= rdy[k];
      end
    end
  end

  // Reference frame: start, LSB-first data, optional parity, stop bits; one entry per bit period.
  function automatic void build(input int id, input logic [8:0] w, output logic [15:0] bits, output int nb);
    int   wl, pm, sb;
    logic p;
    wl = (id == 3) ? 7 : 8;
    pm = (id == 1) ? 2 : (id == 2) ? 1 : 0;
    sb = (id == 3) ? 2 : 1;
    bits = '1;
    bits[0] = 1'b0;
    nb = 1;
    p = 1'b0;
    for (int i = 0; i < wl; i++) begin
      bits[nb] = w[i];
      p = p ^ w[i];
      nb++;
    end
    if (pm != 0) begin
      bits[nb] = (pm == 1) ? ~p : p;
      nb++;
    end
    nb += sb;
  endfunction

  task automatic push_frame(input int id, input logic [8:0] w, input int acc);
    exp_t e;
    e.id  = id;
    e.acc = acc;
    build(id, w, e.bits, e.nb);
    exp_q.push_back(e);
  endtask

  task automatic send(input int id, input logic [8:0] w, input logic l, input bit push, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy[id] && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rdy[id] !== 1'b1) begin
      errors++;
      $display("FAIL send_ready id=%0d ready=%b expected 1", id, rdy[id]);
    end
    dat[id] = w;
    lst[id] = l;
    vld[id] = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    vld[id] = 1'b0;
    if (push) push_frame(id, w, acc);
  endtask

  task automatic check_frames();
    exp_t e;
    int   n;
    logic bad;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = 0;
      while (cyc <= e.acc + e.nb * DIV && n < 3000) begin
        @(negedge clk);
        n++;
      end
      #1;
      for (int b = 0; b < e.nb; b++) begin
        bad = 1'b0;
        for (int c = 0; c < DIV; c++) begin
          if (e.acc + b * DIV + c >= DEPTH || ln[e.id][e.acc + b * DIV + c] !== e.bits[b]) bad = 1'b1;
        end
        checks++;
        if (bad) begin
          errors++;
          $display("FAIL frame id=%0d acc=%0d bit=%0d line_first=%b expected %b",
                   e.id, e.acc, b, ln[e.id][e.acc + b * DIV], e.bits[b]);
        end
      end
    end
  endtask

  task automatic check_len(input int id, input int acc, input int len);
    checks++;
    if (rd[id][acc + len - 1] !== 1'b0 || rd[id][acc + len] !== 1'b1) begin
      errors++;
      $display("FAIL frame_len id=%0d ready@%0d=%b ready@%0d=%b expected 0 then 1",
               id, len - 1, rd[id][acc + len - 1], len, rd[id][acc + len]);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (line[k] !== 1'b1) begin errors++; $display("FAIL reset_line id=%0d got %b expected 1", k, line[k]); end
      checks++;
      if (rdy[k] !== 1'b1) begin errors++; $display("FAIL reset_ready id=%0d got %b expected 1", k, rdy[k]); end
      checks++;
      if (busy[k] !== 1'b0) begin errors++; $display("FAIL reset_busy id=%0d got %b expected 0", k, busy[k]); end
    end
    rst = 1'b0;
  endtask

  task automatic test_frame_8n1();
    int  acc;
    logic low;
    send(0, 9'h0A5, 1'b0, 1'b1, acc);
    check_frames();
    low = 1'b1;
    for (int c = 0; c < 100; c++) if (rd[0][acc + c] !== 1'b0) low = 1'b0;
    checks++;
    if (!low) begin errors++; $display("FAIL ready_low_8n1 got some ready=1 in 100 cycles expected all 0"); end
    check_len(0, acc, 100);
  endtask

  task automatic test_parity();
    int acc;
    send(1, 9'h003, 1'b0, 1'b1, acc);
    check_frames();
    check_len(1, acc, 110);
    send(2, 9'h003, 1'b0, 1'b1, acc);
    check_frames();
    check_len(2, acc, 110);
  endtask

  task automatic test_stop2();
    int acc;
    send(3, 9'h07F, 1'b0, 1'b1, acc);
    check_frames();
    check_len(3, acc, 100);
  endtask

  task automatic test_back_to_back();
    int a1, a2, a3;
    send(0, 9'h03C, 1'b1, 1'b1, a1);
    send(0, 9'h0C3, 1'b0, 1'b1, a2);
    send(0, 9'h05A, 1'b0, 1'b1, a3);
    checks++;
    if (a2 - a1 !== 121) begin errors++; $display("FAIL gap_period got %0d expected 121", a2 - a1); end
    checks++;
    if (a3 - a2 !== 101) begin errors++; $display("FAIL b2b_period got %0d expected 101", a3 - a2); end
    check_frames();
  endtask

  task automatic test_hold_valid();
    int n, nacc;
    n = 0;
    nacc = 0;
    @(negedge clk);
    while (!rdy[0] && n < 500) begin @(negedge clk); n++; end
    for (int i = 0; i < 330; i++) begin
      if (i > 0) @(negedge clk);
      vld[0] = 1'b1;
      dat[0] = 9'($urandom_range(0, 255));
      lst[0] = 1'($urandom_range(0, 1));
      if (rdy[0]) begin
        push_frame(0, dat[0], cyc + 1);
        nacc++;
      end
    end
    @(negedge clk);
    vld[0] = 1'b0;
    checks++;
    if (nacc < 2) begin errors++; $display("FAIL hold_accepts got %0d expected >=2", nacc); end
    check_frames();
  endtask

  task automatic test_reset_midframe();
    int acc, n;
    send(0, 9'h000, 1'b0, 1'b0, acc);
    n = 0;
    while (cyc < acc + 35 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (line[0] !== 1'b0) begin errors++; $display("FAIL midframe_line got %b expected 0", line[0]); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (line[0] !== 1'b1) begin errors++; $display("FAIL abort_line got %b expected 1", line[0]); end
    checks++;
    if (rdy[0] !== 1'b1) begin errors++; $display("FAIL abort_ready got %b expected 1", rdy[0]); end
    checks++;
    if (busy[0] !== 1'b0) begin errors++; $display("FAIL abort_busy got %b expected 0", busy[0]); end
    dat[0] = 9'h096;
    lst[0] = 1'b0;
    vld[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    acc = cyc;
    vld[0] = 1'b0;
    checks++;
    if (line[0] !== 1'b0) begin errors++; $display("FAIL first_accept_start got %b expected 0", line[0]); end
    push_frame(0, 9'h096, acc);
    check_frames();
    check_len(0, acc, 100);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      dat[k] = '0;
      vld[k] = 1'b0;
      lst[k] = 1'b0;
    end
    test_reset();
    test_frame_8n1();
    test_parity();
    test_stop2();
    test_back_to_back();
    test_hold_valid();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_uart_tx.md
AXIS_UART_TX -- requirements
Module: axis_uart_tx

Interface
REQ-001 The block SHALL have parameter clk_rate, default 100000000, meaning the clock frequency in Hz.
REQ-002 The block SHALL have parameter Baud, default 115200, meaning the line bit rate in bit/s.
REQ-003 The block SHALL have parameter Word_len, default 8, meaning data bits per frame; the legal range is 5..9.
REQ-004 The block SHALL have parameter Parity, default 0, meaning 0 = none, 1 = odd, 2 = even.
REQ-005 The block SHALL have parameter Stop_bits, default 1, meaning stop bit count; the legal values are 1 and 2.
REQ-006 The block SHALL have parameter Gap_bits, default 2, meaning idle bit periods inserted after a frame accepted with tx_data_last; 0 disables the gap.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-008 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-009 The block SHALL have port tx_data, input, Word_len bits: the AXI-Stream payload.
REQ-010 The block SHALL have port tx_data_valid, input, 1 bit: AXI-Stream tvalid.
REQ-011 The block SHALL have port tx_data_last, input, 1 bit: AXI-Stream tlast, marking the final word of a packet.
REQ-012 The block SHALL have port tx_data_ready, output, 1 bit: AXI-Stream tready.
REQ-013 The block SHALL have port Uart_tx, output, 1 bit: the registered serial line, idle high.
REQ-014 The block SHALL have port tx_busy, output, 1 bit: high in every state except Idle.

Function
REQ-015 Baud_div SHALL equal clk_rate/Baud using integer truncation; Baud_div < 2 SHALL cause an elaboration error.
REQ-016 The FSM SHALL have the states Idle, Start, Data, Parity, Stop and Gap; an illegal state SHALL go to Idle with Uart_tx = 1.
REQ-017 tx_data_ready SHALL equal (state == Idle), combinationally.
REQ-018 A word SHALL be accepted on a rising edge with tx_data_valid && tx_data_ready.
- On that edge the block SHALL latch tx_data, tx_data_last and the computed parity bit.
- On that edge the block SHALL enter Start and drive Uart_tx = 0, so the start bit begins at the accepting edge.
REQ-019 Each bit SHALL occupy exactly Baud_div clock cycles, timed by a baud counter that runs 0..Baud_div-1 and clears on wrap.
REQ-020 Data bits SHALL be sent LSB first, Word_len bits; the bit counter SHALL wrap from Word_len-1 to 0.
REQ-021 When Parity = 1 the parity bit SHALL equal ~^data; when Parity = 2 it SHALL equal ^data; when Parity = 0 the Parity state SHALL be skipped (Data goes directly to Stop).
REQ-022 The Stop state SHALL drive Uart_tx high for Stop_bits*Baud_div cycles.
REQ-023 After Stop, the FSM SHALL enter Gap if the latched last = 1 and Gap_bits > 0; otherwise it SHALL enter Idle.
REQ-024 The Gap state SHALL drive Uart_tx high for Gap_bits*Baud_div cycles and SHALL then enter Idle.
REQ-025 Idle SHALL last at least 1 cycle, so back-to-back frames have a period of (1+Word_len+P+Stop_bits)*Baud_div + 1 cycles, where P = (Parity != 0).
REQ-026 Changes on tx_data, tx_data_valid or tx_data_last while tx_data_ready = 0 SHALL NOT affect the frame in progress.
REQ-027 With tx_data_valid held high, a new word SHALL be accepted on the first Idle cycle.
REQ-028 The line SHALL be glitch-free: Uart_tx SHALL change only on rising clk edges, from a flop.

Reset
REQ-029 While rst = 1 the block SHALL asynchronously force: state = Idle, counters = 0, shift register = 0, latched last = 0, Uart_tx = 1.
- Consequently tx_data_ready = 1 and tx_data_busy-equivalent tx_busy = 0 during reset.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately, with the line high; no partial frame SHALL resume after reset release.
REQ-031 The first acceptance SHALL be possible on the first rising edge after rst deasserts.

Verification (clk_rate = 1000000, Baud = 100000, so Baud_div = 10)
REQ-032 With Word_len = 8, Parity = 0, Stop_bits = 1, sending 0xA5 with last = 0 SHALL produce line levels 0,1,0,1,0,0,1,0,1,1 of 10 cycles each; ready SHALL be low for 100 cycles and then high.
REQ-033 Sending 0x03 with Parity = 2 SHALL produce a parity bit of 0; with Parity = 1 it SHALL produce a parity bit of 1; each frame SHALL be 110 cycles.
REQ-034 With Stop_bits = 2 and Word_len = 7, sending 0x7F SHALL produce a high stop period of 20 cycles and a frame of 100 cycles.
REQ-035 Sending two words with last = 1 on the first and Gap_bits = 2 SHALL produce a second start bit 121 cycles after the first start bit, versus 101 cycles when last = 0.
REQ-036 Asserting rst at cycle 35 of a frame SHALL drive Uart_tx = 1 and ready = 1 within the same cycle; a word presented after release SHALL then produce a complete, correct frame.
REQ-037 With tx_data_valid held high and tx_data changed every cycle during a frame, only the word present on each accepting edge SHALL be transmitted.
